fpu_minmax_reduce: RTL and testbench

FPU_MINMAX_REDUCE -- requirements
Module: fpu_minmax_reduce

---
 rtl/fpu_minmax_reduce.sv | 159 +++++++++++++++
 tb/tb_fpu_minmax_reduce.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_minmax_reduce.sv
// Streaming IEEE-754 min/max reduction over len_i operands, returning the
// winning value, its zero-based index and a sticky signaling-NaN flag.
// Ports: clk_i, reset_i (sync, active-high); start_i/min_or_max_i/len_i
//   launch a reduction; in_valid_i/in_data_i/in_ready_o stream operands;
//   out_valid_o/out_ready_i hand off result_o, index_o and invalid_o.
module fpu_minmax_reduce #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int CNT_W = 8,
  localparam int FW = 1 + EXP_W + MAN_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             min_or_max_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic [FW-1:0]    in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [FW-1:0]    result_o,
  output logic [CNT_W-1:0] index_o,
  output logic             invalid_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [FW-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [FW-1:0]    acc_q, acc_d;
  logic             allnan_q, allnan_d;
  logic             inv_q, inv_d;

  logic [EXP_W-1:0] op_exp;
  logic [MAN_W-1:0] op_man;
  logic             op_nan;
  logic             op_snan;
  logic             op_gt;
  logic             op_lt;
  logic             take;
  logic             accept;

  // Total order on non-NaN values: sign first, then magnitude,
  // with magnitude order flipped for negatives (-0 < +0).
  function automatic logic gt(input logic [FW-1:0] a,
                              input logic [FW-1:0] b);
    logic [FW-2:0] ma;
    logic [FW-2:0] mb;
    ma = a[FW-2:0];
    mb = b[FW-2:0];
    if (a[FW-1] != b[FW-1]) begin
      gt = ~a[FW-1];
    end else if (a[FW-1]) begin
      gt = ma < mb;
    end else begin
      gt = ma > mb;
    end
  endfunction

  assign op_exp  = in_data_i[FW-2 -: EXP_W];
  assign op_man  = in_data_i[MAN_W-1:0];
  assign op_nan  = (&op_exp) & (|op_man);
  assign op_snan = op_nan & ~op_man[MAN_W-1];
  assign op_gt   = gt(in_data_i, acc_q);
  assign op_lt   = gt(acc_q, in_data_i);

  // Strict compare keeps the earlier index on ties; a NaN never wins.
  assign take = ~op_nan &
                (allnan_q | (mode_q ? op_gt : op_lt));

  assign accept = in_valid_i & in_ready_o;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    allnan_d = allnan_q;
    inv_d    = inv_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d   = min_or_max_i;
          len_d    = len_i;
          cnt_d    = ZERO;
          idx_d    = ZERO;
          acc_d    = QNAN;
          allnan_d = 1'b1;
          inv_d    = 1'b0;
          state_d  = (len_i == ZERO) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + ONE;
          inv_d = inv_q | op_snan;
          if (take) begin
            acc_d    = in_data_i;
            idx_d    = cnt_q;
            allnan_d = 1'b0;
          end
          if (cnt_q == len_q - ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= QNAN;
      allnan_q <= 1'b1;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      allnan_q <= allnan_d;
      inv_q    <= inv_d;
    end
  end

  assign in_ready_o  = (state_q == ACCUM);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = acc_q;
  assign index_o     = idx_q;
  assign invalid_o   = inv_q;

endmodule

// File: tb/tb_fpu_minmax_reduce.sv
// Scoreboard bench for fpu_minmax_reduce at default widths.
// Expected results come from an independent order-key model.
module tb_fpu_minmax_reduce;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [7:0]  len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [7:0]  index;
  logic        invalid;

  fpu_minmax_reduce dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .min_or_max_i (mode),
    .len_i        (len),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .result_o     (result),
    .index_o      (index),
    .invalid_o    (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [7:0]  i;
    logic        inv;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ops[$];
  int          ncmp = 0;
  int          nerr = 0;

  // Map a non-NaN float to an unsigned key with the same ordering.
  function automatic logic [31:0] key(input logic [31:0] v);
    if (v[31]) key = {1'b0, ~v[30:0]};
    else       key = {1'b1, v[30:0]};
  endfunction

  function automatic exp_t model(input bit mx,
                                 input logic [31:0] d[$]);
    exp_t e;
    bit   have;
    bit   nan;
    e.r   = 32'h7FC00000;
    e.i   = 8'd0;
    e.inv = 1'b0;
    have  = 0;
    for (int k = 0; k < d.size(); k++) begin
      nan = (d[k][30:23] == 8'hFF) && (d[k][22:0] != 0);
      if (nan && !d[k][22]) e.inv = 1'b1;
      if (!nan) begin
        if (!have ||
            (mx ? key(d[k]) > key(e.r) : key(d[k]) < key(e.r))) begin
          e.r  = d[k];
          e.i  = 8'(k);
          have = 1;
        end
      end
    end
    return e;
  endfunction

  task automatic do_reduce(input string nm, input bit mx,
                           input bit gaps);
    exp_t e;
    int   w;
    int   n;
    n = ops.size();
    sb.push_back(model(mx, ops));
    @(negedge clk);
    start = 1'b1;
    mode  = mx;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = ops[k];
      ncmp++;
      if (in_ready !== 1'b1) begin
        nerr++;
        $display("FAIL %s ready[%0d]: got %b want 1", nm, k, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    ncmp++;
    if (w != 0) begin
      nerr++;
      $display("FAIL %s latency: got %0d extra cycles want 0", nm, w);
    end
    e = sb.pop_front();
    ncmp++;
    if (result !== e.r || index !== e.i || invalid !== e.inv) begin
      nerr++;
      $display("FAIL %s result: got %h/%0d/%b want %h/%0d/%b",
               nm, result, index, invalid, e.r, e.i, e.inv);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ncmp++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL %s release: got out_valid %b want 0", nm, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ncmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
        result !== 32'h7FC00000 || index !== 8'd0 || invalid !== 1'b0) begin
      nerr++;
      $display("FAIL reset: got v%b r%b %h/%0d/%b want v0 r0 7fc00000/0/0",
               out_valid, in_ready, result, index, invalid);
    end
  endtask

  task automatic test_max3();
    ops = {32'h3F800000, 32'hC0000000, 32'h40600000};
    do_reduce("max3", 1'b1, 1'b0);
  endtask

  task automatic test_signed_zero();
    ops = {32'h00000000, 32'h80000000};
    do_reduce("min_zero", 1'b0, 1'b0);
    do_reduce("max_zero", 1'b1, 1'b0);
  endtask

  task automatic test_nan();
    ops = {32'h7FC00000, 32'h3F800000};
    do_reduce("nan_first", 1'b1, 1'b0);
    ops = {32'h7FC00000, 32'h7F800001};
    do_reduce("all_nan", 1'b1, 1'b0);
    ops = {32'hFF800000, 32'h7F800000, 32'h7FA00000};
    do_reduce("inf_min", 1'b0, 1'b0);
  endtask

  task automatic test_len0_stall();
    exp_t e;
    sb.push_back('{r: 32'h7FC00000, i: 8'd0, inv: 1'b0});
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    len   = 8'd0;
    @(negedge clk);
    start = 1'b0;
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      ncmp++;
      if (out_valid !== 1'b1 || result !== e.r ||
          index !== e.i || invalid !== e.inv) begin
        nerr++;
        $display("FAIL len0[%0d]: got v%b %h/%0d/%b want v1 %h/%0d/%b",
                 k, out_valid, result, index, invalid, e.r, e.i, e.inv);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ncmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL len0 idle: got v%b r%b want v0 r0",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h41000000;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ncmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 ||
        result !== 32'h7FC00000 || index !== 8'd0 || invalid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: got v%b r%b %h/%0d/%b want v0 r0 7fc00000/0/0",
               out_valid, in_ready, result, index, invalid);
    end
    ops = {32'h3F800000};
    do_reduce("after_reset", 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool[8];
    pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
             32'h7FC00000, 32'h7F800001, 32'h3F800000, 32'hBF800000};
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 8);
      ops.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) == 1)
          ops.push_back(pool[$urandom_range(0, 7)]);
        else
          ops.push_back($urandom);
      end
      do_reduce($sformatf("rand%0d", t), t[0], t[1]);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_max3();
    test_signed_zero();
    test_nan();
    test_len0_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
